// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/store requester and memory bus bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          st_req;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_wdata;
  logic          st_gnt;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, st_req, st_addr, st_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, st_gnt,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr, st_req, st_addr, st_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, st_gnt,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for fetch reads and store writes (ROUND_ROBIN_EN selects round-robin tie-break)
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] GRANT_RD  = 2'd1;
  localparam logic [1:0] GRANT_WR  = 2'd2;
  localparam logic [1:0] READ_WAIT = 2'd3;

  logic [1:0]    state;
  logic          pick_store;
  logic          pick_fetch;
  logic [AW-1:0] next_addr;
  logic [DW-1:0] next_wdata;

`ifdef ROUND_ROBIN_EN
  // 1 = store was the last requester served; reset value lets fetch win the first tie
  logic last_store;

  // Remember who was granted so the other side wins the next tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_store <= 1'b1;
    end else if (state == IDLE) begin
      if (pick_store) begin
        last_store <= 1'b1;
      end else if (pick_fetch) begin
        last_store <= 1'b0;
      end
    end
  end
`endif

  // Choose the winner among the requests sampled in IDLE
  always_comb begin
`ifdef ROUND_ROBIN_EN
    pick_store = bus.st_req & (~bus.if_req | ~last_store);
`else
    pick_store = bus.st_req;
`endif
    pick_fetch = bus.if_req & ~pick_store;
    next_addr  = pick_store ? bus.st_addr : bus.if_addr;
    next_wdata = bus.st_wdata;
  end

  // Access sequencer; every output is a register set on entry to the state that owns it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.if_gnt    <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.st_gnt    <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.if_gnt    <= 1'b0;
      bus.st_gnt    <= 1'b0;
      bus.if_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_store) begin
            state         <= GRANT_WR;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= next_addr;
            bus.mem_wdata <= next_wdata;
            bus.st_gnt    <= 1'b1;
            bus.busy      <= 1'b1;
          end else if (pick_fetch) begin
            state         <= GRANT_RD;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= next_addr;
            bus.if_gnt    <= 1'b1;
            bus.busy      <= 1'b1;
          end
        end
        GRANT_WR: begin
          state      <= IDLE;
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.busy   <= 1'b0;
        end
        GRANT_RD: begin
          state      <= READ_WAIT;
          bus.mem_en <= 1'b0;
        end
        READ_WAIT: begin
          state         <= IDLE;
          bus.if_rdata  <= bus.mem_rdata;
          bus.if_rvalid <= 1'b1;
          bus.busy      <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
